// File: rtl/down_counter_pkg.sv
// Shared constants and helpers for the T-flip-flop down counter.
package down_counter_pkg;

   localparam int DC_W_DEFAULT = 3;
   localparam int DC_W_MAX     = 16;

   // Zero-extend narrower vectors to DC_W_MAX before calling.
   function automatic logic dc_zero(input logic [DC_W_MAX-1:0] v);
      return (v == {DC_W_MAX{1'b0}});
   endfunction

endpackage

// File: rtl/down_counter_tff_cell.sv
// Single T flip-flop with asynchronous active-low clear.
module tff_cell (
   output logic q,
   input  logic t,
   input  logic clk,
   input  logic nrst
);

   logic state_d;
   logic state_q;

   // Toggle when t is high, otherwise hold.
   always_comb begin
      state_d = state_q ^ t;
   end

   // State flop with asynchronous clear.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= 1'b0;
      end else begin
         state_q <= state_d;
      end
   end

   assign q = state_q;

endmodule

// File: rtl/down_counter.sv
// W-bit synchronous down counter built from T cells with load, enable and terminal count.
// Define DOWN_COUNTER_RELOAD_EN to reload from the last loaded value on underflow instead of wrapping.
module down_counter
   import down_counter_pkg::*;
#(
   parameter int W = DC_W_DEFAULT
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         load,
   input  logic [W-1:0] d,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         tc,
   output logic         zero
);

   logic [W-1:0]          t;
   logic [W-1:0]          low_zero;
   logic [W-1:0]          wrap_val;
   logic [DC_W_MAX-1:0]   q_ext;

`ifdef DOWN_COUNTER_RELOAD_EN
   logic [W-1:0] reload_d;
   logic [W-1:0] reload_q;

   // Reload register follows every parallel load.
   always_comb begin
      if (load) begin
         reload_d = d;
      end else begin
         reload_d = reload_q;
      end
   end

   // Reload register storage.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         reload_q <= {W{1'b0}};
      end else begin
         reload_q <= reload_d;
      end
   end

   assign wrap_val = reload_q;
`else
   assign wrap_val = {W{1'b1}};
`endif

   // Zero detect on the count, shared with the terminal-count path.
   always_comb begin
      q_ext = {DC_W_MAX{1'b0}};
      q_ext[W-1:0] = q;
      zero = dc_zero(q_ext);
      tc   = en & zero;
   end

   // Toggle enables: a bit flips once every lower bit has reached zero.
   always_comb begin
      low_zero[0] = 1'b1;
      for (int i = 1; i < W; i++) begin
         low_zero[i] = low_zero[i-1] & ~q[i-1];
      end
      if (load) begin
         t = q ^ d;
      end else if (en && zero) begin
         t = q ^ wrap_val;
      end else if (en) begin
         t = low_zero;
      end else begin
         t = {W{1'b0}};
      end
   end

   for (genvar g = 0; g < W; g++) begin : g_cell
      tff_cell u_cell (
         .q    (q[g]),
         .t    (t[g]),
         .clk  (clk),
         .nrst (nrst)
      );
   end

endmodule

// File: tb/tb_down_counter.sv
// Directed scoreboard bench for down_counter, single W=3 counter plus a two-stage cascade.
module tb_down_counter;
   import down_counter_pkg::*;

   logic       clk;
   logic       nrst;
   logic       load;
   logic       en;
   logic [2:0] d;
   logic [2:0] q;
   logic       tc;
   logic       zero;

   logic       c_load;
   logic       c_en;
   logic [2:0] c_dlo;
   logic [2:0] c_dhi;
   logic [2:0] q_lo;
   logic [2:0] q_hi;
   logic       tc_lo;
   logic       tc_hi;
   logic       zero_lo;
   logic       zero_hi;

   int n_vec;
   int n_err;

   logic [2:0] mq, mrl;
   logic [2:0] mlo, mlo_rl, mhi, mhi_rl;
   logic [5:0] sb[$];

   down_counter #(.W(3)) u_dut (
      .clk(clk), .nrst(nrst), .load(load), .d(d), .en(en),
      .q(q), .tc(tc), .zero(zero)
   );

   down_counter #(.W(3)) u_lo (
      .clk(clk), .nrst(nrst), .load(c_load), .d(c_dlo), .en(c_en),
      .q(q_lo), .tc(tc_lo), .zero(zero_lo)
   );

   down_counter #(.W(3)) u_hi (
      .clk(clk), .nrst(nrst), .load(c_load), .d(c_dhi), .en(tc_lo),
      .q(q_hi), .tc(tc_hi), .zero(zero_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic mzero(input logic [2:0] v);
      return dc_zero({13'd0, v});
   endfunction

   // Behavioural next-state: load, else decrement with wrap or reload.
   function automatic logic [2:0] mnext(input logic [2:0] cur, input logic l,
                                        input logic [2:0] dv, input logic e,
                                        input logic [2:0] rl);
      if (l) return dv;
      if (!e) return cur;
      if (cur == 3'd0) begin
`ifdef DOWN_COUNTER_RELOAD_EN
         return rl;
`else
         return 3'd7;
`endif
      end
      return cur - 3'd1;
   endfunction

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq = 3'd0; mrl = 3'd0;
      mlo = 3'd0; mlo_rl = 3'd0; mhi = 3'd0; mhi_rl = 3'd0;
   endtask

   task automatic step(input logic l, input logic e, input logic [2:0] dv);
      load = l; en = e; d = dv;
      #1;
      chk("tc", {5'd0, tc}, {5'd0, e & mzero(mq)});
      chk("zero", {5'd0, zero}, {5'd0, mzero(mq)});
      sb.push_back({3'd0, mnext(mq, l, dv, e, mrl)});
      mq = mnext(mq, l, dv, e, mrl);
      if (l) mrl = dv;
      @(posedge clk); #1;
      chk("q", {3'd0, q}, sb.pop_front());
   endtask

   task automatic cstep(input logic l, input logic e, input logic [2:0] dlo, input logic [2:0] dhi);
      logic       e_hi;
      logic [2:0] nlo, nhi;
      c_load = l; c_en = e; c_dlo = dlo; c_dhi = dhi;
      #1;
      e_hi = e & mzero(mlo);
      chk("tc_lo", {5'd0, tc_lo}, {5'd0, e_hi});
      nlo = mnext(mlo, l, dlo, e, mlo_rl);
      nhi = mnext(mhi, l, dhi, e_hi, mhi_rl);
      sb.push_back({nhi, nlo});
      mlo = nlo; mhi = nhi;
      if (l) begin
         mlo_rl = dlo; mhi_rl = dhi;
      end
      @(posedge clk); #1;
      chk("cascade", {q_hi, q_lo}, sb.pop_front());
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      nrst = 1'b0; load = 1'b0; en = 1'b0; d = 3'd0;
      c_load = 1'b0; c_en = 1'b0; c_dlo = 3'd0; c_dhi = 3'd0;
      model_reset();
      #12;
      chk("rst_q", {3'd0, q}, 6'd0);
      chk("rst_zero", {5'd0, zero}, 6'd1);
      chk("rst_tc_en0", {5'd0, tc}, 6'd0);
      en = 1'b1; #1;
      chk("rst_tc_en1", {5'd0, tc}, 6'd1);
      en = 1'b0;
      nrst = 1'b1;
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a count at q=5.
      step(1'b1, 1'b0, 3'd5);
      en = 1'b1;
      nrst = 1'b0; #1;
      chk("async_q", {3'd0, q}, 6'd0);
      chk("async_zero", {5'd0, zero}, 6'd1);
      chk("async_tc", {5'd0, tc}, 6'd1);
      model_reset();
      #1; nrst = 1'b1;
      step(1'b0, 1'b1, 3'd0);

      // Load 5 and count down through zero.
      step(1'b1, 1'b0, 3'd5);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd0);
      step(1'b0, 1'b1, 3'd0);
      step(1'b0, 1'b1, 3'd0);

      // Load beats decrement while tc is high; then hold.
      step(1'b1, 1'b0, 3'd0);
      step(1'b1, 1'b1, 3'd6);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd3);

      // Period check with value 2 (reload build repeats 2,1,0).
      step(1'b1, 1'b0, 3'd2);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 3'd0);

      // Reload value of 0 pins the counter.
      step(1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd0);

      // Cascade: 0 -> 63 (wrap build), then across 56 -> 55.
      en = 1'b0; load = 1'b0;
      cstep(1'b1, 1'b0, 3'd0, 3'd0);
      cstep(1'b0, 1'b1, 3'd0, 3'd0);
      cstep(1'b1, 1'b0, 3'd0, 3'd7);
      cstep(1'b0, 1'b1, 3'd0, 3'd0);
      cstep(1'b0, 1'b1, 3'd0, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
